tanh_grad: RTL and testbench

- Backward-pass companion to the forward tanh activation unit in the accelerator datapath.
- Takes the stored forward output y = tanh(x) and the upstream gradient g, and returns the local gradient g_in = g * (1 - y^2).
- Fixed-point, fully pipelined, 3-stage, with a valid/ready handshake on both sides so it can sit between the gradient FIFO and the weight-update engine under backpressure.

---
 rtl/tanh_grad.sv | 97 +++++++++
 tb/tb_tanh_grad.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_grad.sv
// tanh_grad: backward pass of the tanh activation, g_in = g * (1 - y^2), signed fixed point.
// Three-stage pipeline sharing one advance enable, so backpressure freezes all stages together.
module tanh_grad #(
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic signed [INT_WIDTH+FRAC_WIDTH-1:0] y,
    input  logic signed [INT_WIDTH+FRAC_WIDTH-1:0] g,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] g_in,
    input  logic                                   clr_err,
    output logic                                   range_err
);
    localparam int W    = INT_WIDTH + FRAC_WIDTH;
    localparam int SQ_W = 2 * W - FRAC_WIDTH;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FRAC_WIDTH;

    logic                  w_en;
    logic signed [2*W-1:0] w_y_sq;
    logic [W:0]            w_abs_y;
    logic                  w_y_oor;
    logic [W-1:0]          w_om;
    logic signed [2*W-1:0] w_p;
    logic                  w_unused;

    logic                  r1_vld;
    logic signed [W-1:0]   r1_g;
    logic [SQ_W-1:0]       r1_sq;
    logic                  r1_oor;
    logic                  r2_vld;
    logic signed [W-1:0]   r2_g;
    logic signed [W-1:0]   r2_om;
    logic                  r3_vld;
    logic signed [W-1:0]   r_g_in;
    logic                  r_range_err;

    assign w_en     = !r3_vld || out_ready;
    assign in_ready = w_en;

    // S1: y^2 is never negative, so the shifted square keeps its top bits as plain magnitude.
    assign w_y_sq  = (2*W)'(y) * (2*W)'(y);
    // One extra bit so negating the most-negative y yields a true magnitude above 1.0.
    assign w_abs_y = y[W-1] ? -{y[W-1], y} : {y[W-1], y};
    assign w_y_oor = w_abs_y > {1'b0, ONE};

    // S2: 1 - y^2, clamped at zero once y^2 reaches 1.0.
    assign w_om = (r1_sq >= {{(SQ_W-W){1'b0}}, ONE}) ? '0 : ONE - r1_sq[W-1:0];

    // S3: om lies in [0, 1.0], so |g * om| never exceeds |g| and needs no saturation.
    assign w_p = (2*W)'(r2_g) * (2*W)'(r2_om);

    assign w_unused = ^{w_y_sq[FRAC_WIDTH-1:0], w_p[2*W-1:W+FRAC_WIDTH], w_p[FRAC_WIDTH-1:0]};

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_vld      <= 1'b0;
            r2_vld      <= 1'b0;
            r3_vld      <= 1'b0;
            r_g_in      <= '0;
            r_range_err <= 1'b0;
        end else begin
            if (w_en) begin
                r1_vld <= in_valid;
                r2_vld <= r1_vld;
                r3_vld <= r2_vld;
                r_g_in <= w_p[W+FRAC_WIDTH-1:FRAC_WIDTH];
            end
            if (w_en && r1_vld && r1_oor) begin
                r_range_err <= 1'b1;
            end else if (clr_err) begin
                r_range_err <= 1'b0;
            end
        end
    end

    // NOTE: datapath registers carry no reset; the stage valid bits decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r1_g   <= g;
            r1_sq  <= w_y_sq[2*W-1:FRAC_WIDTH];
            r1_oor <= w_y_oor;
            r2_g   <= r1_g;
            r2_om  <= w_om;
        end
    end

    assign out_valid = r3_vld;
    assign g_in      = r_g_in;
    assign range_err = r_range_err;

endmodule

// File: tb/tb_tanh_grad.sv
// Bench for tanh_grad: directed boundary cases plus randomized traffic with random backpressure,
// checked by a scoreboard fed from an arithmetic reference model of g * (1 - y^2).
module tb_tanh_grad;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  y;
    logic [W-1:0]  g;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  g_in;
    logic          clr_err;
    logic          range_err;

    logic [31:0]   sb[$];
    logic [31:0]   exp_v;
    logic [31:0]   last_gin;
    logic [31:0]   held_val;
    bit            held_valid = 0;
    bit            saw_stall = 0;
    bit            model_err_seen = 0;
    bit            rand_done = 0;
    int            errors = 0;
    int            checks = 0;

    tanh_grad #(.INT_WIDTH(16), .FRAC_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .g_in      (g_in),
        .clr_err   (clr_err),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: g * (1 - y^2) in plain 64-bit arithmetic, results floored to the 2^-16 grid.
    function automatic logic [31:0] model_gin(input logic signed [31:0] yv, input logic signed [31:0] gv);
        longint yy, sq, om, p;
        yy = longint'(yv) * longint'(yv);
        sq = yy >>> 16;
        om = (sq >= 65536) ? 64'sd0 : 65536 - sq;
        p  = longint'(gv) * om;
        return 32'(p >>> 16);
    endfunction

    function automatic bit model_oor(input logic signed [31:0] yv);
        longint a;
        a = longint'(yv);
        if (a < 0) a = -a;
        return a > 65536;
    endfunction

    // Input side: every accepted pair pushes its expected result.
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready) begin
            sb.push_back(model_gin(y, g));
            if (model_oor(y)) model_err_seen = 1;
        end
    end

    // Output side: pops on each transfer, checks hold-while-stalled and the ready rule.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            held_valid = 0;
            model_err_seen = 0;
        end else begin
            if (held_valid) begin
                check("stall_valid", out_valid, 1);
                check("stall_gin", g_in, held_val);
            end
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (!in_ready) saw_stall = 1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("stale_out", out_valid, 0);
                end else begin
                    exp_v = sb.pop_front();
                    check("g_in", g_in, exp_v);
                    last_gin = g_in;
                end
            end
            held_valid = out_valid && !out_ready;
            held_val   = g_in;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Call just after a rising edge; returns just after the edge that accepted the pair.
    task automatic send(input logic [31:0] yv, input logic [31:0] gv);
        int n = 0;
        y = yv;
        g = gv;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic measure_latency(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic directed(input string name, input logic [31:0] yv, input logic [31:0] gv,
                            input logic [31:0] expected);
        send(yv, gv);
        wait_drain();
        check(name, last_gin, expected);
        sync();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] edge_y[5];
        logic [31:0] v;
        logic [31:0] ry;
        edge_y[0] = 32'h0000_0000;
        edge_y[1] = 32'h0001_0000;
        edge_y[2] = 32'hFFFF_0000;
        edge_y[3] = 32'h8000_0000;
        edge_y[4] = 32'h0001_0001;

        reset = 1; in_valid = 0; y = '0; g = '0; out_ready = 1; clr_err = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_g_in", g_in, 0);
        check("rst_range_err", range_err, 0);
        check("rst_in_ready", in_ready, 1);
        sync();

        // y = 0 passes g straight through, three cycles after acceptance.
        send(32'h0000_0000, 32'h0001_0000);
        measure_latency(lat);
        check("latency", lat, 3);
        wait_drain();
        check("zero_y_gin", last_gin, 32'h0001_0000);
        check("zero_y_err", range_err, 0);
        sync();

        directed("half_pos", 32'h0000_8000, 32'h0002_0000, 32'h0001_8000);
        directed("half_neg", 32'hFFFF_8000, 32'h0002_0000, 32'h0001_8000);
        directed("one_pos", 32'h0001_0000, 32'h1234_5678, 32'h0000_0000);
        directed("one_neg", 32'hFFFF_0000, 32'h1234_5678, 32'h0000_0000);
        check("unit_no_err", range_err, 0);
        directed("quarter_negg", 32'h0000_4000, 32'hFFFF_0000, 32'hFFFF_1000);

        // Out-of-range y: zero gradient and a sticky error until cleared.
        directed("oor_gin", 32'h0001_8000, 32'h0001_0000, 32'h0000_0000);
        check("oor_err_set", range_err, 1);
        repeat (3) sync();
        check("oor_err_sticky", range_err, 1);
        clr_err = 1;
        sync();
        clr_err = 0;
        model_err_seen = 0;
        @(negedge clk);
        check("oor_err_clr", range_err, 0);
        sync();

        // Eight back-to-back samples with the output stalled for five cycles.
        saw_stall = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'h0000_1000 * i - 32'h0000_4000, 32'h0003_0000 - 32'h0000_9000 * i);
            end
            begin
                repeat (3) sync();
                out_ready = 0;
                repeat (5) sync();
                out_ready = 1;
            end
        join
        wait_drain();
        check("stream_stalled", saw_stall, 1);
        sync();

        // Reset with three samples in flight.
        send(32'h0000_2000, 32'h0004_0000);
        send(32'h0000_3000, 32'h0005_0000);
        send(32'h0000_5000, 32'h0006_0000);
        reset = 1;
        sync();
        reset = 0;
        @(negedge clk);
        check("rst_mid_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", out_valid, 0);
        end
        sync();
        send(32'h0000_8000, 32'h0002_0000);
        measure_latency(lat);
        check("rst_new_latency", lat, 3);
        wait_drain();
        check("rst_new_gin", last_gin, 32'h0001_8000);
        sync();

        // Randomized traffic with random bubbles and random backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    case ($urandom_range(0, 3))
                        0: ry = $urandom;
                        3: ry = edge_y[$urandom_range(0, 4)];
                        default: begin
                            v  = $urandom_range(0, 32'h0001_0000);
                            ry = ($urandom_range(0, 1) == 1) ? -v : v;
                        end
                    endcase
                    if ($urandom_range(0, 4) == 0) sync();
                    send(ry, $urandom);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    sync();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1;
            end
        join
        wait_drain();
        check("rand_range_err", range_err, model_err_seen);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
